// File: rtl/pe_op_sequencer.sv
// rtl/pe_op_sequencer.sv - sequences multi-beat PE operations and tracks opcode/PE-output history
module pe_op_sequencer #(
    parameter int P = 128,
    parameter int Q = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [3:0]         cmd_opcode,
    input  logic [10:0]        cmd_nv,
    output logic               cmd_ready,
    input  logic [2*P*Q-1:0]   pe_o,
    output logic [3:0]         opcode,
    output logic [10:0]        I_Nv,
    output logic [3:0]         channel_cnt,
    output logic [3:0]         opcode_before,
    output logic [3:0]         opcode_delay,
    output logic [2*P*Q-1:0]   pe_o_before,
    output logic               busy,
    output logic               op_done,
    output logic               cmd_err
);

    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [10:0]        i_nv_q, i_nv_d;
    logic [3:0]         channel_cnt_q, channel_cnt_d;
    logic [1:0]         last_q, last_d;
    logic [3:0]         opcode_before_q, opcode_before_d;
    logic [3:0]         opcode_delay_q, opcode_delay_d;
    logic [2*P*Q-1:0]   pe_o_before_q, pe_o_before_d;
    logic               op_done_q, op_done_d;
    logic               cmd_err_q, cmd_err_d;

    logic               last_beat;
    logic               accept;
    logic               legal;
    logic [1:0]         cmd_last;

    assign last_beat = (state_q == RUN) && (channel_cnt_q == {2'b00, last_q});
    assign cmd_ready = !rst && ((state_q == IDLE) || last_beat);
    assign accept    = cmd_valid && cmd_ready;

    // Legal lengths are the powers of two 2..1024; bit 0 set rules out 1.
    assign legal    = (cmd_nv != 11'd0) && ((cmd_nv & (cmd_nv - 11'd1)) == 11'd0) && !cmd_nv[0];
    assign cmd_last = cmd_nv[10] ? 2'd3 : (cmd_nv[9] ? 2'd1 : 2'd0);

    always_comb begin
        state_d         = state_q;
        opcode_d        = opcode_q;
        i_nv_d          = i_nv_q;
        channel_cnt_d   = channel_cnt_q;
        last_d          = last_q;
        opcode_before_d = op_done_q ? opcode_q : opcode_before_q;
        opcode_delay_d  = opcode_q;
        pe_o_before_d   = pe_o;
        cmd_err_d       = accept && !legal;

        if (state_q == RUN && !last_beat) begin
            channel_cnt_d = channel_cnt_q + 4'd1;
        end else if (accept && legal) begin
            state_d       = RUN;
            opcode_d      = cmd_opcode;
            i_nv_d        = cmd_nv;
            channel_cnt_d = 4'd0;
            last_d        = cmd_last;
        end else begin
            state_d       = IDLE;
            opcode_d      = OP_NOP;
            i_nv_d        = 11'd0;
            channel_cnt_d = 4'd0;
            last_d        = 2'd0;
        end

        // Registered so the pulse lines up with the beat it marks.
        op_done_d = (state_d == RUN) && (channel_cnt_d == {2'b00, last_d});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            opcode_q        <= OP_NOP;
            i_nv_q          <= 11'd0;
            channel_cnt_q   <= 4'd0;
            last_q          <= 2'd0;
            opcode_before_q <= OP_NOP;
            opcode_delay_q  <= OP_NOP;
            pe_o_before_q   <= '0;
            op_done_q       <= 1'b0;
            cmd_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            i_nv_q          <= i_nv_d;
            channel_cnt_q   <= channel_cnt_d;
            last_q          <= last_d;
            opcode_before_q <= opcode_before_d;
            opcode_delay_q  <= opcode_delay_d;
            pe_o_before_q   <= pe_o_before_d;
            op_done_q       <= op_done_d;
            cmd_err_q       <= cmd_err_d;
        end
    end

    assign opcode        = opcode_q;
    assign I_Nv          = i_nv_q;
    assign channel_cnt   = channel_cnt_q;
    assign opcode_before = opcode_before_q;
    assign opcode_delay  = opcode_delay_q;
    assign pe_o_before   = pe_o_before_q;
    assign busy          = (state_q == RUN);
    assign op_done       = op_done_q;
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_pe_op_sequencer.sv
// tb/tb_pe_op_sequencer.sv - scoreboard bench for pe_op_sequencer
module tb_pe_op_sequencer;

    localparam int P = 128;
    localparam int Q = 6;
    localparam int W = 2 * P * Q;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic [3:0]     cmd_opcode;
    logic [10:0]    cmd_nv;
    logic           cmd_ready;
    logic [W-1:0]   pe_o;
    logic [3:0]     opcode;
    logic [10:0]    I_Nv;
    logic [3:0]     channel_cnt;
    logic [3:0]     opcode_before;
    logic [3:0]     opcode_delay;
    logic [W-1:0]   pe_o_before;
    logic           busy;
    logic           op_done;
    logic           cmd_err;

    pe_op_sequencer #(.P(P), .Q(Q)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
        .cmd_nv(cmd_nv), .cmd_ready(cmd_ready), .pe_o(pe_o), .opcode(opcode),
        .I_Nv(I_Nv), .channel_cnt(channel_cnt), .opcode_before(opcode_before),
        .opcode_delay(opcode_delay), .pe_o_before(pe_o_before), .busy(busy),
        .op_done(op_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        err;
        logic [3:0]  opc;
        logic [10:0] nv;
        logic [3:0]  cnt;
        logic        done;
    } exp_t;

    localparam exp_t IDLE_EXP = '{busy: 1'b0, err: 1'b0, opc: 4'hF, nv: 11'd0, cnt: 4'd0, done: 1'b0};

    exp_t q[$];
    int   tests  = 0;
    int   errors = 0;
    bit   ramp_mode = 1'b0;
    int   ramp_k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: an op of length nv occupies ceil(nv/256) beats; only powers of two 2..1024 are legal.
    task automatic model_accept(input logic [3:0] opc, input logic [10:0] nv);
        int beats;
        bit ok;
        exp_t e;
        ok = 1'b0;
        for (int v = 2; v <= 1024; v = v * 2)
            if (int'(nv) == v) ok = 1'b1;
        if (!ok) begin
            e = IDLE_EXP;
            e.err = 1'b1;
            q.push_back(e);
        end else begin
            beats = (int'(nv) + 255) / 256;
            for (int b = 0; b < beats; b++) begin
                e.busy = 1'b1; e.err = 1'b0; e.opc = opc; e.nv = nv;
                e.cnt = 4'(b); e.done = (b == beats - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called at negedge+1; returns just before the accepting rising edge.
    task automatic issue(input logic [3:0] opc, input logic [10:0] nv);
        bit done_wait;
        done_wait = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        cmd_nv     = nv;
        for (int i = 0; i < 12 && !done_wait; i++) begin
            #3;
            if (cmd_ready) begin
                model_accept(opc, nv);
                done_wait = 1'b1;
            end else begin
                step();
            end
        end
        if (!done_wait) begin
            tests++; errors++;
            $display("FAIL accept_timeout: got no cmd_ready in 12 cycles, expected accept");
        end
    endtask

    task automatic go_idle(input int n);
        step();
        cmd_valid = 1'b0;
        cmd_opcode = 4'($urandom);
        cmd_nv = 11'($urandom);
        for (int i = 1; i < n; i++) step();
    endtask

    // pe_o changes only just after falling edges, so it is stable at each rising edge.
    initial begin
        pe_o = '0;
        forever begin
            @(negedge clk);
            #1;
            if (ramp_mode) begin
                ramp_k++;
                pe_o = W'(ramp_k);
            end else begin
                for (int i = 0; i < W / 32; i++) pe_o[i*32 +: 32] = $urandom;
            end
        end
    end

    // Monitor: every falling edge presents one output cycle; the queue front is its expectation.
    logic [3:0] prev_opc = 4'hF;
    logic [3:0] before_model = 4'hF;
    initial begin
        exp_t e;
        logic [3:0] exp_before, exp_delay;
        logic [W-1:0] exp_peb;
        logic exp_ready;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                e = IDLE_EXP;
                exp_before = 4'hF; exp_delay = 4'hF; exp_peb = '0; exp_ready = 1'b0;
                before_model = 4'hF;
            end else begin
                e = (q.size() > 0) ? q.pop_front() : IDLE_EXP;
                exp_before = before_model;
                exp_delay  = prev_opc;
                exp_peb    = pe_o;
                exp_ready  = !e.busy || e.done;
            end
            chk("busy",          32'(busy),          32'(e.busy));
            chk("opcode",        32'(opcode),        32'(e.opc));
            chk("I_Nv",          32'(I_Nv),          32'(e.nv));
            chk("channel_cnt",   32'(channel_cnt),   32'(e.cnt));
            chk("op_done",       32'(op_done),       32'(e.done));
            chk("cmd_err",       32'(cmd_err),       32'(e.err));
            chk("cmd_ready",     32'(cmd_ready),     32'(exp_ready));
            chk("opcode_before", 32'(opcode_before), 32'(exp_before));
            chk("opcode_delay",  32'(opcode_delay),  32'(exp_delay));
            tests++;
            if (pe_o_before !== exp_peb) begin
                errors++;
                $display("FAIL pe_o_before at %0t: got low %h expected low %h", $time, pe_o_before[63:0], exp_peb[63:0]);
            end
            prev_opc = e.opc;
            if (e.done) before_model = e.opc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] nv;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_nv = 11'd0;
        step(); step();
        rst = 1'b0;
        step();

        issue(4'b0000, 11'd1024);
        go_idle(3);

        issue(4'b0001, 11'd512);
        step();
        step();
        issue(4'b0000, 11'd128);
        go_idle(3);

        issue(4'b0011, 11'd300);
        go_idle(3);

        ramp_mode = 1'b1;
        issue(4'b0010, 11'd64);
        go_idle(4);
        ramp_mode = 1'b0;

        // Four single-beat ops back to back.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            issue(4'b0010, 11'd2);
        end
        go_idle(3);

        // Reset during beat 2 of a four-beat op, with a command offered in the reset cycle.
        issue(4'b0000, 11'd1024);
        step(); step(); step();
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = 4'b0001; cmd_nv = 11'd2;
        #3;
        chk("cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        step();
        rst = 1'b0;
        cmd_valid = 1'b0;
        step(); step();

        // Boundary lengths, then random traffic.
        issue(4'b0001, 11'd1); go_idle(2);
        issue(4'b0001, 11'd256); go_idle(2);
        issue(4'b0001, 11'd0); go_idle(2);
        issue(4'b0001, 11'd2047); go_idle(2);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) nv = 11'(1 << $urandom_range(1, 10));
            else nv = 11'($urandom);
            issue(4'($urandom_range(0, 15)), nv);
            case ($urandom_range(0, 2))
                0: step();
                1: go_idle(1);
                default: go_idle($urandom_range(2, 4));
            endcase
        end
        go_idle(8);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pe_op_sequencer.md
PE_OP_SEQUENCER -- requirements
Module: pe_op_sequencer

Interface
REQ-001 SHALL have parameter P, default 128, meaning PE lanes per output half.
REQ-002 SHALL have parameter Q, default 6, meaning LLR bit width per lane.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  operation command present.
REQ-006 SHALL have port cmd_opcode  input  4  operation: 0000 type1, 0001 type2, 0010 bottom, 0011 type3.
REQ-007 SHALL have port cmd_nv  input  11  node length I_Nv of the command.
REQ-008 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-009 SHALL have port pe_o  input  2*P*Q  current PE output (two halves).
REQ-010 SHALL have port opcode  output  4  opcode of the running op; 1111 (NOP) when idle.
REQ-011 SHALL have port I_Nv  output  11  node length of the running op; 0 when idle.
REQ-012 SHALL have port channel_cnt  output  4  beat index within the running op.
REQ-013 SHALL have port opcode_before  output  4  opcode of the previously finished op.
REQ-014 SHALL have port opcode_delay  output  4  opcode delayed one clock.
REQ-015 SHALL have port pe_o_before  output  2*P*Q  pe_o delayed one clock.
REQ-016 SHALL have port busy  output  1  op in progress.
REQ-017 SHALL have port op_done  output  1  one-cycle pulse on last beat of an op.
REQ-018 SHALL have port cmd_err  output  1  one-cycle pulse when an illegal command is accepted.

Function
REQ-019 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-020 SHALL treat cmd_nv legal only if a power of two in 2..1024; beat count N = 1 for cmd_nv <= 256, 2 for 512, 4 for 1024.
REQ-021 SHALL drive cmd_ready = 1 in IDLE, and in RUN only on the last beat (channel_cnt == N-1), enabling back-to-back ops with no bubble.
REQ-022 SHALL, on accept of a legal command, register opcode and I_Nv, set channel_cnt = 0, enter/stay RUN; outputs valid the cycle after accept.
REQ-023 SHALL, on accept of an illegal command, pulse cmd_err the next cycle, start no op, and go/stay IDLE (ending any finishing op normally).
REQ-024 SHALL increment channel_cnt by 1 each RUN cycle until N-1; opcode and I_Nv held constant across all beats.
REQ-025 SHALL assert op_done on the cycle channel_cnt == N-1 in RUN (N=1: every RUN cycle of that op).
REQ-026 SHALL, on last beat with no accept, return to IDLE next cycle: opcode = 1111, I_Nv = 0, channel_cnt = 0, busy = 0.
REQ-027 SHALL load opcode_before with the opcode of each op at its op_done cycle (visible next cycle); NOP idle cycles do not update it.
REQ-028 SHALL register opcode_delay <= opcode and pe_o_before <= pe_o every cycle, unconditionally.
REQ-029 SHALL drive busy = 1 exactly when state is RUN.
REQ-030 SHALL ignore cmd_opcode/cmd_nv when cmd_valid or cmd_ready is low.

Reset
REQ-031 SHALL on rst force: state IDLE, opcode 1111, I_Nv 0, channel_cnt 0, opcode_before 1111, opcode_delay 1111, pe_o_before 0, busy 0, op_done 0, cmd_err 0.
REQ-032 SHALL on rst mid-op abort without op_done; a cmd_valid in the rst cycle is not accepted (cmd_ready low during rst).

Verification
REQ-033 SHALL cover: cmd (0000, 1024) -> busy 4 cycles, channel_cnt 0,1,2,3, op_done on cnt 3, then opcode 1111, I_Nv 0.
REQ-034 SHALL cover: back-to-back (0001,512) then (0000,128) held valid -> cnt 0,1,0 with no idle cycle; opcode_before = 0001 when second op runs.
REQ-035 SHALL cover: cmd (0011, 300) -> cmd_err pulse one cycle, busy stays 0, opcode 1111.
REQ-036 SHALL cover: pe_o ramp value k at cycle k -> pe_o_before = k-1 at cycle k; opcode_delay trails opcode by exactly one cycle.
REQ-037 SHALL cover: rst asserted at channel_cnt 2 of a 1024 op -> next cycle all outputs at REQ-031 values, no op_done.
REQ-038 SHALL cover: four consecutive (0010, 2) commands -> four consecutive op_done pulses, channel_cnt constant 0, busy high throughout.
